// File: rtl/score_tracker_if.sv
// score_tracker_if: session control, per-lane hit pulses and score readout bundle.
`default_nettype none

interface score_tracker_if #(
  parameter int unsigned SCORE_W = 20,
  parameter int unsigned COMBO_W = 10
);
  logic               start;
  logic               song_end;
  logic [3:0]         hit_perfect;
  logic [3:0]         hit_okay;
  logic [3:0]         hit_miss;
  logic [SCORE_W-1:0] score;
  logic [COMBO_W-1:0] combo;
  logic [COMBO_W-1:0] max_combo;
  logic [COMBO_W-1:0] n_perfect;
  logic [COMBO_W-1:0] n_okay;
  logic [COMBO_W-1:0] n_miss;
  logic [2:0]         multiplier;
  logic               combo_break;
  logic               playing;
  logic               result_valid;

  modport master (
    output start, song_end, hit_perfect, hit_okay, hit_miss,
    input  score, combo, max_combo, n_perfect, n_okay, n_miss,
           multiplier, combo_break, playing, result_valid
  );

  modport slave (
    input  start, song_end, hit_perfect, hit_okay, hit_miss,
    output score, combo, max_combo, n_perfect, n_okay, n_miss,
           multiplier, combo_break, playing, result_valid
  );
endinterface

`default_nettype wire

// File: rtl/score_tracker.sv
// +--------------------------------------------------------------------------+
// | score_tracker: per-song score/combo/tally accumulator with combo tiers.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module score_tracker #(
  parameter int unsigned SCORE_W     = 20,
  parameter int unsigned COMBO_W     = 10,
  parameter int unsigned PERFECT_PTS = 100,
  parameter int unsigned OKAY_PTS    = 50,
  parameter int unsigned TIER2_COMBO = 10,
  parameter int unsigned TIER4_COMBO = 30
) (
  input  logic           clk,
  input  logic           reset,
  score_tracker_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PLAYING = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam int unsigned        WIDE_W         = SCORE_W + 32;
  localparam logic [SCORE_W-1:0] SCORE_MAX      = '1;
  localparam logic [WIDE_W-1:0]  SCORE_MAX_WIDE = WIDE_W'(SCORE_MAX);
  localparam logic [COMBO_W-1:0] TIER2          = COMBO_W'(TIER2_COMBO);
  localparam logic [COMBO_W-1:0] TIER4          = COMBO_W'(TIER4_COMBO);

  logic [1:0] state;
  logic [1:0] state_next;
  logic       is_playing;
  logic       is_done;
  logic       begin_session;

  logic [SCORE_W-1:0] score_r;
  logic [COMBO_W-1:0] combo_r;
  logic [COMBO_W-1:0] max_combo_r;
  logic [COMBO_W-1:0] n_perfect_r;
  logic [COMBO_W-1:0] n_okay_r;
  logic [COMBO_W-1:0] n_miss_r;
  logic               combo_break_r;

  logic [3:0]         eff_perfect;
  logic [3:0]         eff_okay;
  logic [3:0]         eff_miss;
  logic [2:0]         cnt_p;
  logic [2:0]         cnt_o;
  logic [2:0]         cnt_m;
  logic [2:0]         mult;
  logic [31:0]        gain;
  logic [WIDE_W-1:0]  score_wide;
  logic [SCORE_W-1:0] score_next;
  logic [COMBO_W-1:0] combo_next;
  logic [COMBO_W-1:0] max_combo_next;
  logic               break_next;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [COMBO_W-1:0] sat_add(input logic [COMBO_W-1:0] a,
                                                 input logic [3:0] b);
    logic [COMBO_W:0] s;
    s = {1'b0, a} + (COMBO_W + 1)'(b);
    return s[COMBO_W] ? {COMBO_W{1'b1}} : s[COMBO_W-1:0];
  endfunction

  // Session FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Session FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (bus.start)    state_next = ST_PLAYING;
      ST_PLAYING: if (bus.song_end) state_next = ST_DONE;
      ST_DONE:    if (bus.start)    state_next = ST_PLAYING;
      default:                      state_next = ST_IDLE;
    endcase
  end

  // Session FSM: outputs
  always_comb begin
    is_playing    = (state == ST_PLAYING);
    is_done       = (state == ST_DONE);
    begin_session = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
  end

  // One grade per lane per cycle, perfect beats okay beats miss.
  always_comb begin
    eff_perfect = bus.hit_perfect;
    eff_okay    = bus.hit_okay & ~bus.hit_perfect;
    eff_miss    = bus.hit_miss & ~(bus.hit_perfect | bus.hit_okay);
    cnt_p       = popcount4(eff_perfect);
    cnt_o       = popcount4(eff_okay);
    cnt_m       = popcount4(eff_miss);
  end

  always_comb begin
    if (combo_r >= TIER4) begin
      mult = 3'd4;
    end else if (combo_r >= TIER2) begin
      mult = 3'd2;
    end else begin
      mult = 3'd1;
    end
  end

  // Score is accumulated wide and then clamped so it never wraps.
  always_comb begin
    gain       = (32'(cnt_p) * PERFECT_PTS + 32'(cnt_o) * OKAY_PTS) * 32'(mult);
    score_wide = WIDE_W'(score_r) + WIDE_W'(gain);
    score_next = (score_wide > SCORE_MAX_WIDE) ? SCORE_MAX : score_wide[SCORE_W-1:0];
  end

  always_comb begin
    combo_next     = (cnt_m != 3'd0) ? '0 : sat_add(combo_r, 4'(cnt_p) + 4'(cnt_o));
    max_combo_next = (combo_next > max_combo_r) ? combo_next : max_combo_r;
    break_next     = (cnt_m != 3'd0) && (combo_r != '0);
  end

  always_ff @(posedge clk) begin
    if (reset || begin_session) begin
      score_r       <= '0;
      combo_r       <= '0;
      max_combo_r   <= '0;
      n_perfect_r   <= '0;
      n_okay_r      <= '0;
      n_miss_r      <= '0;
      combo_break_r <= 1'b0;
    end else if (is_playing) begin
      score_r       <= score_next;
      combo_r       <= combo_next;
      max_combo_r   <= max_combo_next;
      n_perfect_r   <= sat_add(n_perfect_r, 4'(cnt_p));
      n_okay_r      <= sat_add(n_okay_r, 4'(cnt_o));
      n_miss_r      <= sat_add(n_miss_r, 4'(cnt_m));
      combo_break_r <= break_next;
    end else begin
      combo_break_r <= 1'b0;
    end
  end

  assign bus.score        = score_r;
  assign bus.combo        = combo_r;
  assign bus.max_combo    = max_combo_r;
  assign bus.n_perfect    = n_perfect_r;
  assign bus.n_okay       = n_okay_r;
  assign bus.n_miss       = n_miss_r;
  assign bus.multiplier   = mult;
  assign bus.combo_break  = combo_break_r;
  assign bus.playing      = is_playing;
  assign bus.result_valid = is_done;

endmodule

`default_nettype wire

// File: tb/tb_score_tracker.sv
// tb_score_tracker: directed and randomized checks of score_tracker against a behavioural model.
`default_nettype none

module tb_score_tracker;
  localparam int SCORE_W = 20;
  localparam int COMBO_W = 10;
  localparam int SMAX    = (1 << SCORE_W) - 1;
  localparam int CMAX    = (1 << COMBO_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  score_tracker_if #(.SCORE_W(SCORE_W), .COMBO_W(COMBO_W)) bif ();
  score_tracker dut (.clk(clk), .reset(reset), .bus(bif));

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of one song session
  int m_score, m_combo, m_max, m_np, m_no, m_nm;
  bit m_in_song, m_have_result, m_break;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int exp_mult();
    return (m_combo >= 30) ? 4 : ((m_combo >= 10) ? 2 : 1);
  endfunction

  task automatic model_clear();
    m_score = 0; m_combo = 0; m_max = 0; m_np = 0; m_no = 0; m_nm = 0; m_break = 0;
  endtask

  task automatic model_step(input bit rs, input bit st, input bit se,
                            input logic [3:0] pf, input logic [3:0] ok, input logic [3:0] ms);
    int p, o, m, mul;
    if (rs) begin
      model_clear();
      m_in_song = 0; m_have_result = 0;
    end else if (!m_in_song) begin
      m_break = 0;
      if (st) begin
        model_clear();
        m_in_song = 1; m_have_result = 0;
      end
    end else begin
      p = 0; o = 0; m = 0;
      for (int l = 0; l < 4; l++) begin
        if (pf[l]) p++;
        else if (ok[l]) o++;
        else if (ms[l]) m++;
      end
      mul     = exp_mult();
      m_score = imin(m_score + (p * 100 + o * 50) * mul, SMAX);
      m_break = (m > 0) && (m_combo != 0);
      m_combo = (m > 0) ? 0 : imin(m_combo + p + o, CMAX);
      if (m_combo > m_max) m_max = m_combo;
      m_np = imin(m_np + p, CMAX);
      m_no = imin(m_no + o, CMAX);
      m_nm = imin(m_nm + m, CMAX);
      if (se) begin
        m_in_song = 0; m_have_result = 1;
      end
    end
  endtask

  task automatic drive(input bit rs, input bit st, input bit se,
                       input logic [3:0] pf, input logic [3:0] ok, input logic [3:0] ms);
    @(negedge clk);
    reset = rs; bif.start = st; bif.song_end = se;
    bif.hit_perfect = pf; bif.hit_okay = ok; bif.hit_miss = ms;
    @(posedge clk);
    model_step(rs, st, se, pf, ok, ms);
    #1;
  endtask

  task automatic restart();
    drive(0, 0, 1, 4'h0, 4'h0, 4'h0);
    drive(0, 1, 0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 4'hF, 4'h0, 4'h0);
    drive(1, 1, 0, 4'h0, 4'hF, 4'h0);
    n_tests++; if ({bif.score, bif.combo, bif.max_combo, bif.n_perfect, bif.n_okay, bif.n_miss} !== '0) begin
      n_fail++; $display("FAIL reset_counters: got score=%0d combo=%0d required all 0", bif.score, bif.combo); end
    n_tests++; if (bif.multiplier !== 3'd1) begin n_fail++; $display("FAIL reset_mult: got %0d required 1", bif.multiplier); end
    n_tests++; if ({bif.playing, bif.result_valid, bif.combo_break} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b required 000", {bif.playing, bif.result_valid, bif.combo_break}); end
  endtask

  task automatic test_single_perfect();
    drive(0, 0, 0, 4'h1, 4'h0, 4'h0);
    n_tests++; if (bif.score !== 0) begin n_fail++; $display("FAIL idle_hit_ignored: got %0d required 0", bif.score); end
    drive(0, 1, 0, 4'hF, 4'h0, 4'h0);
    n_tests++; if (bif.playing !== 1'b1 || bif.score !== 0) begin
      n_fail++; $display("FAIL start_cycle: got playing=%b score=%0d required 1/0", bif.playing, bif.score); end
    drive(0, 0, 0, 4'h1, 4'h0, 4'h0);
    n_tests++; if (bif.score !== 100) begin n_fail++; $display("FAIL single_score: got %0d required 100", bif.score); end
    n_tests++; if (bif.combo !== 1 || bif.n_perfect !== 1) begin
      n_fail++; $display("FAIL single_combo: got combo=%0d n_perfect=%0d required 1/1", bif.combo, bif.n_perfect); end
  endtask

  task automatic test_multiplier();
    restart();
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 4'h1, 4'h0, 4'h0);
    n_tests++; if (bif.score !== 1000 || bif.multiplier !== 3'd2) begin
      n_fail++; $display("FAIL tier2_entry: got score=%0d mult=%0d required 1000/2", bif.score, bif.multiplier); end
    drive(0, 1, 0, 4'h1, 4'h0, 4'h0);
    n_tests++; if (bif.score !== 1200) begin n_fail++; $display("FAIL tier2_score: got %0d required 1200", bif.score); end
    n_tests++; if (bif.combo !== 11 || bif.multiplier !== 3'd2 || bif.playing !== 1'b1) begin
      n_fail++; $display("FAIL tier2_combo: got combo=%0d mult=%0d required 11/2", bif.combo, bif.multiplier); end
  endtask

  task automatic test_combo_break();
    restart();
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 4'h1, 4'h0, 4'h0);
    drive(0, 0, 0, 4'b0011, 4'h0, 4'b0100);
    n_tests++; if (bif.score !== 700 || bif.combo !== 0) begin
      n_fail++; $display("FAIL break_score: got score=%0d combo=%0d required 700/0", bif.score, bif.combo); end
    n_tests++; if (bif.max_combo !== 5 || bif.n_miss !== 1) begin
      n_fail++; $display("FAIL break_max: got max=%0d n_miss=%0d required 5/1", bif.max_combo, bif.n_miss); end
    n_tests++; if (bif.combo_break !== 1'b1) begin n_fail++; $display("FAIL break_pulse: got %b required 1", bif.combo_break); end
    drive(0, 0, 0, 4'h0, 4'h0, 4'h0);
    n_tests++; if (bif.combo_break !== 1'b0) begin n_fail++; $display("FAIL break_one_cycle: got %b required 0", bif.combo_break); end
    drive(0, 0, 0, 4'h0, 4'h0, 4'h1);
    n_tests++; if (bif.combo_break !== 1'b0 || bif.n_miss !== 2) begin
      n_fail++; $display("FAIL break_zero_combo: got brk=%b n_miss=%0d required 0/2", bif.combo_break, bif.n_miss); end
  endtask

  task automatic test_priority();
    drive(0, 0, 0, 4'b0001, 4'b0001, 4'b0001);
    n_tests++; if (bif.score !== 800 || bif.n_okay !== 0 || bif.n_perfect !== 8 || bif.n_miss !== 2) begin
      n_fail++; $display("FAIL priority: got score=%0d np=%0d no=%0d nm=%0d required 800/8/0/2",
                         bif.score, bif.n_perfect, bif.n_okay, bif.n_miss); end
  endtask

  task automatic test_song_end();
    drive(0, 0, 1, 4'h0, 4'h1, 4'h0);
    n_tests++; if (bif.score !== 850 || bif.n_okay !== 1) begin
      n_fail++; $display("FAIL end_hit_counted: got score=%0d n_okay=%0d required 850/1", bif.score, bif.n_okay); end
    n_tests++; if (bif.result_valid !== 1'b1 || bif.playing !== 1'b0) begin
      n_fail++; $display("FAIL end_state: got rv=%b playing=%b required 1/0", bif.result_valid, bif.playing); end
    drive(0, 0, 0, 4'hF, 4'h0, 4'hF);
    drive(0, 0, 1, 4'h0, 4'hF, 4'h0);
    n_tests++; if (bif.score !== 850 || bif.n_miss !== 2 || bif.result_valid !== 1'b1) begin
      n_fail++; $display("FAIL done_frozen: got score=%0d n_miss=%0d rv=%b required 850/2/1", bif.score, bif.n_miss, bif.result_valid); end
    drive(0, 1, 0, 4'hF, 4'h0, 4'h0);
    n_tests++; if ({bif.score, bif.combo, bif.max_combo, bif.n_perfect, bif.n_okay, bif.n_miss} !== '0
                   || bif.playing !== 1'b1 || bif.result_valid !== 1'b0) begin
      n_fail++; $display("FAIL restart_clear: got score=%0d np=%0d playing=%b required 0/0/1", bif.score, bif.n_perfect, bif.playing); end
  endtask

  task automatic test_reset_mid_song();
    drive(0, 0, 0, 4'h3, 4'h4, 4'h0);
    drive(1, 0, 0, 4'h1, 4'h0, 4'h0);
    n_tests++; if (bif.score !== 0 || bif.n_okay !== 0 || bif.playing !== 1'b0 || bif.result_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_song: got score=%0d playing=%b required 0/0", bif.score, bif.playing); end
  endtask

  task automatic test_saturation();
    drive(0, 1, 0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 2000 && m_score < SMAX; i++) drive(0, 0, 0, 4'hF, 4'h0, 4'h0);
    n_tests++; if (bif.score !== SCORE_W'(SMAX)) begin n_fail++; $display("FAIL score_sat: got %0d required %0d", bif.score, SMAX); end
    n_tests++; if (bif.combo !== COMBO_W'(CMAX) || bif.n_perfect !== COMBO_W'(CMAX) || bif.multiplier !== 3'd4) begin
      n_fail++; $display("FAIL combo_sat: got combo=%0d np=%0d mult=%0d required %0d/%0d/4", bif.combo, bif.n_perfect, bif.multiplier, CMAX, CMAX); end
    drive(0, 0, 0, 4'hF, 4'h0, 4'h0);
    n_tests++; if (bif.score !== SCORE_W'(SMAX)) begin n_fail++; $display("FAIL score_no_wrap: got %0d required %0d", bif.score, SMAX); end
  endtask

  task automatic test_random();
    bit rs, st, se;
    logic [3:0] pf, ok, ms;
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 24) == 0);
      se = ($urandom_range(0, 39) == 0);
      pf = 4'($urandom) & 4'($urandom);
      ok = 4'($urandom) & 4'($urandom);
      ms = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      drive(rs, st, se, pf, ok, ms);
      n_tests++; if (bif.score !== SCORE_W'(m_score)) begin n_fail++; $display("FAIL rnd_score[%0d]: got %0d required %0d", i, bif.score, m_score); end
      n_tests++; if (bif.combo !== COMBO_W'(m_combo)) begin n_fail++; $display("FAIL rnd_combo[%0d]: got %0d required %0d", i, bif.combo, m_combo); end
      n_tests++; if (bif.max_combo !== COMBO_W'(m_max)) begin n_fail++; $display("FAIL rnd_max[%0d]: got %0d required %0d", i, bif.max_combo, m_max); end
      n_tests++; if ({bif.n_perfect, bif.n_okay, bif.n_miss} !== {COMBO_W'(m_np), COMBO_W'(m_no), COMBO_W'(m_nm)}) begin
        n_fail++; $display("FAIL rnd_tally[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d", i,
                           bif.n_perfect, bif.n_okay, bif.n_miss, m_np, m_no, m_nm); end
      n_tests++; if (bif.multiplier !== 3'(exp_mult())) begin n_fail++; $display("FAIL rnd_mult[%0d]: got %0d required %0d", i, bif.multiplier, exp_mult()); end
      n_tests++; if ({bif.combo_break, bif.playing, bif.result_valid} !== {m_break, m_in_song, m_have_result}) begin
        n_fail++; $display("FAIL rnd_flags[%0d]: got %b required %b", i,
                           {bif.combo_break, bif.playing, bif.result_valid}, {m_break, m_in_song, m_have_result}); end
    end
  endtask

  initial begin
    reset = 1'b1; bif.start = 1'b0; bif.song_end = 1'b0;
    bif.hit_perfect = 4'h0; bif.hit_okay = 4'h0; bif.hit_miss = 4'h0;
    model_clear(); m_in_song = 0; m_have_result = 0;
    test_reset();
    test_single_perfect();
    test_multiplier();
    test_combo_break();
    test_priority();
    test_song_end();
    test_reset_mid_song();
    test_saturation();
    drive(1, 0, 0, 4'h0, 4'h0, 4'h0);
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
